// File: rtl/chien_search.sv
// Chien search: sweeps sigma(alpha^j) for j = 0..PARAM_N-1 using constant
// multiply-by-alpha^k cells, streams one root flag per position and a final root count.
module chien_search #(
  parameter int                PARAM_M    = 4,
  parameter int                PARAM_T    = 2,
  parameter int                PARAM_N    = 15,
  parameter logic [PARAM_M:0]  PARAM_POLY = 5'b10011
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [(PARAM_T+1)*PARAM_M-1:0]     sigma_in_i,
  output logic                               busy_o,
  output logic                               root_valid_o,
  output logic [$clog2(PARAM_N)-1:0]         root_pos_o,
  output logic                               root_flag_o,
  output logic                               done_o,
  output logic [$clog2(PARAM_N+1)-1:0]       root_count_o
);

  localparam int PW = $clog2(PARAM_N);
  localparam int CW = $clog2(PARAM_N+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Single multiply-by-alpha step: shift left, reduce by the primitive polynomial.
  function automatic logic [PARAM_M-1:0] mul_alpha(input logic [PARAM_M-1:0] a);
    logic [PARAM_M-1:0] shifted;
    shifted = {a[PARAM_M-2:0], 1'b0};
    if (a[PARAM_M-1]) begin
      return shifted ^ PARAM_POLY[PARAM_M-1:0];
    end else begin
      return shifted;
    end
  endfunction

  // Constant multiply by alpha^k as k chained alpha steps; k is static per term.
  function automatic logic [PARAM_M-1:0] mul_alpha_k(input logic [PARAM_M-1:0] a,
                                                     input int k);
    logic [PARAM_M-1:0] acc;
    acc = a;
    for (int i = 0; i < k; i++) begin
      acc = mul_alpha(acc);
    end
    return acc;
  endfunction

  state_t               state_q;
  logic [PARAM_M-1:0]   reg_q [0:PARAM_T];
  logic [PARAM_M-1:0]   reg_d [0:PARAM_T];
  logic [PW-1:0]        j_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [PARAM_M-1:0]   sum_s;
  logic                 flag_s;

  logic                 busy_q;
  logic                 root_valid_q;
  logic [PW-1:0]        root_pos_q;
  logic                 root_flag_q;
  logic                 done_q;
  logic [CW-1:0]        root_count_q;

  // Evaluate sigma at the current position and advance each term by alpha^k.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k <= PARAM_T; k++) begin
      sum_s    = sum_s ^ reg_q[k];
      reg_d[k] = mul_alpha_k(reg_q[k], k);
    end
    flag_s = (sum_s == '0);
    cnt_d  = cnt_q + CW'(flag_s);
  end

  // Sweep FSM with registered outputs; busy stays high through the done cycle,
  // so a start seen in IDLE while busy_q is still set is the done-cycle start and is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      j_q          <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      root_valid_q <= 1'b0;
      root_pos_q   <= '0;
      root_flag_q  <= 1'b0;
      done_q       <= 1'b0;
      root_count_q <= '0;
      for (int k = 0; k <= PARAM_T; k++) begin
        reg_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          root_valid_q <= 1'b0;
          root_flag_q  <= 1'b0;
          done_q       <= 1'b0;
          if (start_i && !busy_q) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            j_q     <= '0;
            cnt_q   <= '0;
            for (int k = 0; k <= PARAM_T; k++) begin
              reg_q[k] <= sigma_in_i[k*PARAM_M +: PARAM_M];
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          root_valid_q <= 1'b1;
          root_pos_q   <= j_q;
          root_flag_q  <= flag_s;
          cnt_q        <= cnt_d;
          j_q          <= j_q + PW'(1);
          for (int k = 0; k <= PARAM_T; k++) begin
            reg_q[k] <= reg_d[k];
          end
          if (j_q == PW'(PARAM_N - 1)) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          root_valid_q <= 1'b0;
          root_flag_q  <= 1'b0;
          done_q       <= 1'b1;
          root_count_q <= cnt_q;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          root_valid_q <= 1'b0;
          root_flag_q  <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign root_valid_o = root_valid_q;
  assign root_pos_o   = root_pos_q;
  assign root_flag_o  = root_flag_q;
  assign done_o       = done_q;
  assign root_count_o = root_count_q;

endmodule

// File: tb/tb_chien_search.sv
// Directed bench for chien_search over GF(16), x^4+x+1, T=2, N=15.
// Expected flag masks and counts are hand-derived from the alpha power table.
module tb_chien_search;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] sigma;
  logic        busy;
  logic        root_valid;
  logic [3:0]  root_pos;
  logic        root_flag;
  logic        done;
  logic [3:0]  root_count;

  int checks = 0;
  int errors = 0;

  chien_search dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .sigma_in_i   (sigma),
    .busy_o       (busy),
    .root_valid_o (root_valid),
    .root_pos_o   (root_pos),
    .root_flag_o  (root_flag),
    .done_o       (done),
    .root_count_o (root_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"},  32'(busy),       32'd0);
    chk({tag, ".valid"}, 32'(root_valid), 32'd0);
    chk({tag, ".pos"},   32'(root_pos),   32'd0);
    chk({tag, ".flag"},  32'(root_flag),  32'd0);
    chk({tag, ".done"},  32'(done),       32'd0);
    chk({tag, ".count"}, 32'(root_count), 32'd0);
  endtask

  // Full sweep starting in the current cycle c; ends in cycle c+18 with busy low.
  // poke pulses start during busy and in the done cycle, both of which must be ignored.
  task automatic run_sweep(input string tag, input logic [11:0] sig,
                           input logic [14:0] mask, input logic [3:0] cnt,
                           input bit poke);
    sigma = sig;
    start = 1'b1;
    tick();                                   // cycle c+1
    start = 1'b0;
    sigma = ~sig;                             // sigma must only be sampled at start
    chk({tag, ".busy1"},  32'(busy),       32'd1);
    chk({tag, ".valid1"}, 32'(root_valid), 32'd0);
    for (int j = 0; j < 15; j++) begin
      start = (poke && j == 7) ? 1'b1 : 1'b0;
      tick();                                 // cycle c+2+j
      start = 1'b0;
      chk($sformatf("%s.valid%0d", tag, j), 32'(root_valid), 32'd1);
      chk($sformatf("%s.pos%0d",   tag, j), 32'(root_pos),   32'(j));
      chk($sformatf("%s.flag%0d",  tag, j), 32'(root_flag),  32'(mask[j]));
      chk($sformatf("%s.busyr%0d", tag, j), 32'(busy),       32'd1);
      chk($sformatf("%s.doner%0d", tag, j), 32'(done),       32'd0);
    end
    tick();                                   // cycle c+17: done
    chk({tag, ".done"},      32'(done),       32'd1);
    chk({tag, ".count"},     32'(root_count), 32'(cnt));
    chk({tag, ".busy_done"}, 32'(busy),       32'd1);
    chk({tag, ".valid_end"}, 32'(root_valid), 32'd0);
    start = poke;
    tick();                                   // cycle c+18
    start = 1'b0;
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".done_after"}, 32'(done), 32'd0);
    chk({tag, ".count_held"}, 32'(root_count), 32'(cnt));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    sigma = 12'h011;
    tick();
    chk_idle_zero("rst1");
    tick();
    chk_idle_zero("rst2");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk_idle_zero("post_rst");

    // sigma = 1 + x: only root at alpha^0
    run_sweep("one_root", 12'h011, 15'h0001, 4'd1, 1'b0);
    // (x+a^3)(x+a^5) = x^2 + a^11 x + a^8
    run_sweep("two_roots", 12'h1E5, 15'h0028, 4'd2, 1'b0);
    // all-zero sigma flags every position
    run_sweep("zero", 12'h000, 15'h7FFF, 4'd15, 1'b0);
    // x^2+x+1 roots a^5, a^10; ignored starts; next sweep starts at c+18 back-to-back
    run_sweep("gf4", 12'h111, 15'h0420, 4'd2, 1'b1);
    run_sweep("const", 12'h002, 15'h0000, 4'd0, 1'b0);

    // Reset while position 7 is on the outputs
    sigma = 12'h1E5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid.pos7", 32'(root_pos), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("mid.rst");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("mid.nodone%0d", i), 32'(done), 32'd0);
      chk($sformatf("mid.nobusy%0d", i), 32'(busy), 32'd0);
    end
    run_sweep("after_rst", 12'h1E5, 15'h0028, 4'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chien_search.md
# chien_search

Root-search stage that sits directly downstream of the key-equation solver and is built from constant multiply-by-α^k cells, the same primitive as `mul_alpha`. It takes an error-locator polynomial σ(x) of degree ≤ PARAM_T over GF(2^PARAM_M). Over PARAM_N consecutive cycles it evaluates σ(α^j) for j = 0..PARAM_N-1 and streams one root flag per position. When the sweep ends it reports the total root count.

## Interface
- PARAM_M, 4: field width m; elements are PARAM_M-bit polynomial-basis vectors.
- PARAM_T, 2: maximum locator degree.
- PARAM_N, 15: number of positions swept.
- PARAM_POLY, 5'b10011: primitive polynomial, PARAM_M+1 bits (default x^4+x+1); α = 0…010.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- sigma_in  in  (PARAM_T+1)*PARAM_M  σ_k in bits [k*PARAM_M +: PARAM_M]; sampled in the start cycle only.
- busy  out  1  sweep in progress, including the done cycle.
- root_valid  out  1  root_pos/root_flag valid this cycle.
- root_pos  out  $clog2(PARAM_N)  position index j.
- root_flag  out  1  1 when σ(α^j) = 0.
- done  out  1  one-cycle pulse at end of sweep.
- root_count  out  $clog2(PARAM_N+1)  number of flags set; valid while done=1 and held until the next start.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → DONE after the evaluation for j = PARAM_N-1 is issued.
  - DONE → IDLE unconditionally.
- On the start edge:
  - reg_k ← σ_k for k = 0..PARAM_T.
  - j ← 0, internal count ← 0.
- Each RUN cycle:
  - sum = XOR of all reg_k (GF addition).
  - Registered outputs load root_valid=1, root_pos=j, root_flag=(sum==0).
  - count increments when the flag is set.
  - Registers update reg_k ← reg_k·α^k, j ← j+1.
- Multiply by α^k is a fixed combinational network derived from PARAM_POLY (k chained multiply-by-α steps, each a shift plus conditional XOR of PARAM_POLY[PARAM_M-1:0]).
  - reg_0 is never changed.
  - No general multipliers are used.
- All arithmetic is in GF(2^PARAM_M); no carries. count is plain binary and cannot overflow because it is at most PARAM_N.
- start is ignored while busy=1, including in the DONE cycle.
- An all-zero σ is legal: every position is flagged and root_count = PARAM_N.
- The block does not check degree or consistency; the consumer compares root_count with deg σ.

## Timing
- Start sampled high in cycle c:
  - busy=1 for cycles c+1 .. c+PARAM_N+2.
  - root_valid=1 for cycles c+2 .. c+PARAM_N+1, carrying j = cycle − (c+2).
  - done=1 in cycle c+PARAM_N+2 with the final root_count.
  - The earliest accepted next start is in cycle c+PARAM_N+3.
- Throughput: one position per cycle; no backpressure.
- Reset values (rst=1 at any edge, including mid-sweep):
  - State goes to IDLE.
  - busy, root_valid, root_flag, done = 0; root_pos, root_count = 0.
  - Internal registers are cleared.
  - No done pulse is produced for an aborted sweep.
- rst has priority over start in the same cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset state: hold rst 2 cycles with start=1 → all outputs 0, busy stays 0 and no sweep begins; after rst falls, start=1 begins a normal sweep.
- Single root: σ = 1+x (σ0=0001, σ1=0001, σ2=0000), start in cycle c.
  - root_valid high in cycles c+2..c+16.
  - root_flag=1 only at root_pos=0.
  - done in cycle c+17 with root_count=1.
- Two roots: σ0=0101, σ1=1110, σ2=0001, i.e. (x+α^3)(x+α^5).
  - Flags at root_pos=3 and 5 only.
  - root_count=2.
- All-zero σ → flag=1 at all 15 positions; root_count=15.
- No roots and back-to-back operation:
  - σ0=0001, σ1=0001, σ2=0001 (x^2+x+1, roots in GF(4) ⊂ GF(16): α^5 and α^10).
    - Flags at 5 and 10.
    - A start pulsed during busy and in the done cycle is ignored.
    - A start in cycle c+18 is accepted.
  - σ0=0010, σ1=0000, σ2=0000 (nonzero constant α) → no flags; root_count=0.
- Reset mid-sweep: assert rst at j=7 → next cycle all outputs 0; no done pulse; a subsequent start sweeps correctly from j=0.
